// File: rtl/tbird_seq_lights.sv
// Thunderbird taillight sequencer with internal prescaler, hazard flash, brake overlay and abort.
// Lamps and mode update one clk after the tick cycle or input change; no backpressure.
module tbird_seq_lights #(
  parameter int LAMPS = 3,
  parameter int DIV   = 12500000,
  localparam int CW   = $clog2(DIV + 1),
  localparam int SW   = $clog2(LAMPS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left,
  input  logic             right,
  input  logic             hazard,
  input  logic             brake,
  output logic [LAMPS-1:0] lamp_l,
  output logic [LAMPS-1:0] lamp_r,
  output logic [1:0]       mode
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2,
    HAZ   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    step_q, step_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LAMPS-1:0] lamp_l_q, lamp_l_d;
  logic [LAMPS-1:0] lamp_r_q, lamp_r_d;
  logic [1:0]       mode_q, mode_d;
  logic             tick;
  logic             haz_req;

  function automatic logic [LAMPS-1:0] therm(input logic [SW-1:0] s);
    logic [LAMPS-1:0] t;
    for (int i = 0; i < LAMPS; i++) begin
      t[i] = (i < int'(s));
    end
    return t;
  endfunction

  assign tick    = (cnt_q == CW'(DIV - 1));
  assign haz_req = hazard | (left & right);
  assign cnt_d   = tick ? '0 : cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      IDLE: begin
        if (tick) begin
          if (haz_req) begin
            state_d = HAZ;
            step_d  = SW'(1);
          end else if (left) begin
            state_d = LEFT;
            step_d  = SW'(1);
          end else if (right) begin
            state_d = RIGHT;
            step_d  = SW'(1);
          end
        end
      end
      LEFT, RIGHT: begin
        // Aborts act on the clock edge, the animation only on ticks.
        if (hazard || (state_q == LEFT ? right : left)) begin
          state_d = HAZ;
          step_d  = SW'(1);
        end else if (!(state_q == LEFT ? left : right)) begin
          state_d = IDLE;
          step_d  = '0;
        end else if (tick) begin
          if (step_q == '0) begin
            state_d = IDLE;
          end else if (step_q < SW'(LAMPS)) begin
            step_d = step_q + SW'(1);
          end else begin
            step_d = '0;
          end
        end
      end
      HAZ: begin
        if (!haz_req) begin
          state_d = IDLE;
          step_d  = '0;
        end else if (tick) begin
          step_d = (step_q == SW'(1)) ? '0 : SW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = '0;
      end
    endcase
  end

  // Lamps are decoded from the next state so they move in the same edge as the state.
  always_comb begin
    lamp_l_d = brake ? '1 : '0;
    lamp_r_d = brake ? '1 : '0;
    mode_d   = state_d;
    case (state_d)
      LEFT:  lamp_l_d = therm(step_d);
      RIGHT: lamp_r_d = therm(step_d);
      HAZ: begin
        lamp_l_d = (brake || step_d == SW'(1)) ? '1 : '0;
        lamp_r_d = (brake || step_d == SW'(1)) ? '1 : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      state_q  <= IDLE;
      step_q   <= '0;
      lamp_l_q <= '0;
      lamp_r_q <= '0;
      mode_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      step_q   <= step_d;
      lamp_l_q <= lamp_l_d;
      lamp_r_q <= lamp_r_d;
      mode_q   <= mode_d;
    end
  end

  assign lamp_l = lamp_l_q;
  assign lamp_r = lamp_r_q;
  assign mode   = mode_q;

endmodule

// File: tb/tb_tbird_seq_lights.sv
// Bench for tbird_seq_lights: three parameterisations driven in parallel against a reference model.
module tb_tbird_seq_lights;

  logic clk = 1'b0;
  logic reset, left, right, hazard, brake;
  logic [2:0] a_l, a_r, c_l, c_r;
  logic [3:0] b_l, b_r;
  logic [1:0] a_m, b_m, c_m;

  int errors = 0;
  int checks = 0;

  // Instance table: A=(3 lamps, DIV 1), B=(4 lamps, DIV 4), C=(3 lamps, DIV 2)
  int lp [3] = '{3, 4, 3};
  int dp [3] = '{1, 4, 2};

  int m_cnt [3];
  int m_st  [3];
  int m_stp [3];
  logic [3:0] exp_l [3];
  logic [3:0] exp_r [3];
  logic [1:0] exp_m [3];

  always #5 clk = ~clk;

  tbird_seq_lights #(.LAMPS(3), .DIV(1)) u_a (
    .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard), .brake(brake),
    .lamp_l(a_l), .lamp_r(a_r), .mode(a_m));
  tbird_seq_lights #(.LAMPS(4), .DIV(4)) u_b (
    .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard), .brake(brake),
    .lamp_l(b_l), .lamp_r(b_r), .mode(b_m));
  tbird_seq_lights #(.LAMPS(3), .DIV(2)) u_c (
    .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard), .brake(brake),
    .lamp_l(c_l), .lamp_r(c_r), .mode(c_m));

  function automatic logic [3:0] get_l(input int i);
    case (i)
      0:       return {1'b0, a_l};
      1:       return b_l;
      default: return {1'b0, c_l};
    endcase
  endfunction

  function automatic logic [3:0] get_r(input int i);
    case (i)
      0:       return {1'b0, a_r};
      1:       return b_r;
      default: return {1'b0, c_r};
    endcase
  endfunction

  function automatic logic [1:0] get_m(input int i);
    case (i)
      0:       return a_m;
      1:       return b_m;
      default: return c_m;
    endcase
  endfunction

  // Model: mode 0 idle, 1 left, 2 right, 3 hazard; step counts lit lamps (or flash phase).
  task automatic model_advance();
    for (int i = 0; i < 3; i++) begin
      int  ones, turn, bk, own, other;
      bit  tk, hz;
      tk = (m_cnt[i] == dp[i] - 1);
      hz = hazard || (left && right);
      if (reset) begin
        m_cnt[i] = 0; m_st[i] = 0; m_stp[i] = 0;
      end else begin
        m_cnt[i] = tk ? 0 : m_cnt[i] + 1;
        if (m_st[i] == 0) begin
          if (tk) begin
            if (hz)         begin m_st[i] = 3; m_stp[i] = 1; end
            else if (left)  begin m_st[i] = 1; m_stp[i] = 1; end
            else if (right) begin m_st[i] = 2; m_stp[i] = 1; end
          end
        end else if (m_st[i] == 3) begin
          if (!hz) begin m_st[i] = 0; m_stp[i] = 0; end
          else if (tk) m_stp[i] = 1 - m_stp[i];
        end else begin
          own   = (m_st[i] == 1) ? int'(left) : int'(right);
          other = (m_st[i] == 1) ? int'(right) : int'(left);
          if (hazard || other != 0) begin m_st[i] = 3; m_stp[i] = 1; end
          else if (own == 0) begin m_st[i] = 0; m_stp[i] = 0; end
          else if (tk) begin
            if (m_stp[i] == 0) m_st[i] = 0;
            else m_stp[i] = (m_stp[i] + 1) % (lp[i] + 1);
          end
        end
      end
      ones = (1 << lp[i]) - 1;
      turn = (1 << m_stp[i]) - 1;
      bk   = brake ? ones : 0;
      if (reset) begin
        exp_l[i] = 4'd0; exp_r[i] = 4'd0;
      end else if (m_st[i] == 3) begin
        exp_l[i] = 4'((brake || m_stp[i] == 1) ? ones : 0);
        exp_r[i] = exp_l[i];
      end else begin
        exp_l[i] = 4'((m_st[i] == 1) ? turn : bk);
        exp_r[i] = 4'((m_st[i] == 2) ? turn : bk);
      end
      exp_m[i] = 2'(m_st[i]);
    end
  endtask

  task automatic clk_step();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clk_step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    left = 0; right = 0; hazard = 1; brake = 1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (get_l(i) !== 4'd0 || get_r(i) !== 4'd0 || get_m(i) !== 2'd0) begin
        errors++;
        $display("FAIL reset inst%0d: got l=%b r=%b m=%0d, expected all zero", i, get_l(i), get_r(i), get_m(i));
      end
    end
    hazard = 0; brake = 0;
  endtask

  task automatic test_left();
    logic [3:0] seq_l [10] = '{4'd1, 4'd3, 4'd7, 4'd0, 4'd0, 4'd1, 4'd3, 4'd7, 4'd0, 4'd0};
    logic [1:0] seq_m [10] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
    do_reset();
    left = 1;
    for (int c = 0; c < 10; c++) begin
      clk_step();
      checks++;
      if (get_l(0) !== seq_l[c] || get_r(0) !== 4'd0 || get_m(0) !== seq_m[c]) begin
        errors++;
        $display("FAIL left_seq cyc%0d: got l=%b r=%b m=%0d, expected l=%b r=0000 m=%0d",
                 c, get_l(0), get_r(0), get_m(0), seq_l[c], seq_m[c]);
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (get_l(i) !== exp_l[i] || get_r(i) !== exp_r[i] || get_m(i) !== exp_m[i]) begin
          errors++;
          $display("FAIL left inst%0d cyc%0d: got l=%b r=%b m=%0d, expected l=%b r=%b m=%0d",
                   i, c, get_l(i), get_r(i), get_m(i), exp_l[i], exp_r[i], exp_m[i]);
        end
      end
    end
    left = 0;
  endtask

  task automatic test_right_div();
    do_reset();
    right = 1;
    for (int c = 1; c <= 14; c++) begin
      clk_step();
      if (c == 3 || c == 4 || c == 8 || c == 12) begin
        checks++;
        if (get_r(1) !== ((c == 3) ? 4'd0 : (c == 4) ? 4'd1 : (c == 8) ? 4'd3 : 4'd7) || get_l(1) !== 4'd0) begin
          errors++;
          $display("FAIL right_div clk%0d: got r=%b l=%b", c, get_r(1), get_l(1));
        end
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (get_l(i) !== exp_l[i] || get_r(i) !== exp_r[i] || get_m(i) !== exp_m[i]) begin
          errors++;
          $display("FAIL right inst%0d cyc%0d: got l=%b r=%b m=%0d, expected l=%b r=%b m=%0d",
                   i, c, get_l(i), get_r(i), get_m(i), exp_l[i], exp_r[i], exp_m[i]);
        end
      end
    end
    right = 0;
  endtask

  task automatic test_hazard_brake();
    do_reset();
    for (int c = 0; c < 24; c++) begin
      hazard = (c < 9);
      brake  = (c >= 12);
      left   = (c >= 12 && c < 20);
      clk_step();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (get_l(i) !== exp_l[i] || get_r(i) !== exp_r[i] || get_m(i) !== exp_m[i]) begin
          errors++;
          $display("FAIL haz_brake inst%0d cyc%0d: got l=%b r=%b m=%0d, expected l=%b r=%b m=%0d",
                   i, c, get_l(i), get_r(i), get_m(i), exp_l[i], exp_r[i], exp_m[i]);
        end
      end
    end
    hazard = 0; brake = 0; left = 0;
  endtask

  task automatic test_abort();
    for (int k = 0; k < 2; k++) begin
      do_reset();
      left = 1;
      for (int c = 0; c < 4; c++) clk_step();
      checks++;
      if (get_l(2) !== 4'd3) begin
        errors++;
        $display("FAIL abort_pre k%0d: got l=%b, expected 0011", k, get_l(2));
      end
      if (k == 0) right = 1; else left = 0;
      clk_step();
      checks++;
      if (get_l(2) !== ((k == 0) ? 4'd7 : 4'd0) || get_m(2) !== ((k == 0) ? 2'd3 : 2'd0)) begin
        errors++;
        $display("FAIL abort k%0d: got l=%b m=%0d", k, get_l(2), get_m(2));
      end
      left = 0; right = 0;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    hazard = 1;
    for (int c = 0; c < 6; c++) clk_step();
    do_reset();
    checks++;
    if (get_l(1) !== 4'd0 || get_r(1) !== 4'd0 || get_m(1) !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid: got l=%b r=%b m=%0d, expected zeros", get_l(1), get_r(1), get_m(1));
    end
    for (int c = 1; c <= 4; c++) begin
      clk_step();
      checks++;
      if (get_m(1) !== ((c == 4) ? 2'd3 : 2'd0)) begin
        errors++;
        $display("FAIL reset_mid_tick clk%0d: got m=%0d", c, get_m(1));
      end
    end
    hazard = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(7) == 0) left   = ~left;
      if ($urandom_range(7) == 0) right  = ~right;
      if ($urandom_range(15) == 0) hazard = ~hazard;
      if ($urandom_range(9) == 0) brake  = ~brake;
      reset = ($urandom_range(99) == 0);
      clk_step();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (get_l(i) !== exp_l[i] || get_r(i) !== exp_r[i] || get_m(i) !== exp_m[i]) begin
          errors++;
          $display("FAIL random inst%0d cyc%0d: got l=%b r=%b m=%0d, expected l=%b r=%b m=%0d",
                   i, c, get_l(i), get_r(i), get_m(i), exp_l[i], exp_r[i], exp_m[i]);
        end
      end
    end
    reset = 0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_st[i] = 0; m_stp[i] = 0;
    end
    reset = 1; left = 0; right = 0; hazard = 0; brake = 0;
    #2;
    test_reset();
    test_left();
    test_right_div();
    test_hazard_brake();
    test_abort();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
